// File: rtl/mem_request_queue_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_request_queue_if
// Purpose  : Parser/scheduler-facing bundle of the memory request queue.
//            master = the environment (parser + scheduler), slave = the queue.
//            Optional statistics signals appear when QUEUE_STATS_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
interface mem_request_queue_if #(
  parameter int DEPTH         = 16,
  parameter int ADDRESS_WIDTH = 32
);
  localparam int OCC_WIDTH = $clog2(DEPTH) + 1;

  // parser side
  logic                     in_op_ready_s;
  logic [1:0]               in_opcode;
  logic [ADDRESS_WIDTH-1:0] in_address;
  logic [31:0]              in_clock_count;
  logic                     queue_full;

  // scheduler side
  logic                     out_valid;
  logic [1:0]               out_opcode;
  logic [ADDRESS_WIDTH-1:0] out_address;
  logic [31:0]              out_clock_count;
  logic [1:0]               out_bank_group;
  logic [1:0]               out_bank;
  logic [7:0]               out_column;
  logic [9:0]               out_row;
  logic [6:0]               out_life;
  logic                     out_expired;
  logic                     pop;
  logic [OCC_WIDTH-1:0]     occupancy;

`ifdef QUEUE_STATS_EN
  logic [OCC_WIDTH-1:0]     peak_occupancy;
  logic [15:0]              reject_count;
`endif

  modport master (
    output in_op_ready_s, in_opcode, in_address, in_clock_count, pop,
    input  queue_full, out_valid, out_opcode, out_address, out_clock_count,
           out_bank_group, out_bank, out_column, out_row, out_life,
           out_expired, occupancy
`ifdef QUEUE_STATS_EN
           , peak_occupancy, reject_count
`endif
  );

  modport slave (
    input  in_op_ready_s, in_opcode, in_address, in_clock_count, pop,
    output queue_full, out_valid, out_opcode, out_address, out_clock_count,
           out_bank_group, out_bank, out_column, out_row, out_life,
           out_expired, occupancy
`ifdef QUEUE_STATS_EN
           , peak_occupancy, reject_count
`endif
  );
endinterface
`default_nettype wire

// File: rtl/mem_request_queue.sv
`default_nettype none
// ============================================================================
// Module   : mem_request_queue
// Purpose  : DEPTH-entry circular FIFO between the trace parser and the DRAM
//            command scheduler. Ages every buffered entry each cycle and
//            presents the head with its address split into bank group, bank,
//            row and column. Optional statistics (peak occupancy, rejected
//            push count) are built when the macro QUEUE_STATS_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module mem_request_queue #(
  parameter int DEPTH         = 16,
  parameter int ADDRESS_WIDTH = 32,
  parameter int BG_OFFSET     = 6,
  parameter int BANK_OFFSET   = 8,
  parameter int COLUMN_OFFSET = 10,
  parameter int ROW_OFFSET    = 18,
  parameter int MAX_LIFE      = 100
) (
  input  logic               clock,
  input  logic               reset,
  mem_request_queue_if.slave bus
);
  localparam int         PTR_WIDTH = $clog2(DEPTH);
  localparam int         OCC_WIDTH = $clog2(DEPTH) + 1;
  localparam logic [1:0] c_op_nop  = 2'd3;
  localparam logic [6:0] c_life_sat = 7'd127;
  localparam logic [6:0] c_max_life = 7'(MAX_LIFE);
  localparam logic [OCC_WIDTH-1:0] c_full = OCC_WIDTH'(DEPTH);

  logic [1:0]               r_opcode      [DEPTH];
  logic [ADDRESS_WIDTH-1:0] r_address     [DEPTH];
  logic [31:0]              r_clock_count [DEPTH];
  logic [6:0]               r_life        [DEPTH];
  logic [DEPTH-1:0]         r_valid;
  logic [PTR_WIDTH-1:0]     r_rd_ptr;
  logic [PTR_WIDTH-1:0]     r_wr_ptr;
  logic [OCC_WIDTH-1:0]     r_occupancy;

  logic                     w_head_valid;
  logic                     w_pop;
  logic                     w_req;
  logic                     w_push;
  logic [OCC_WIDTH-1:0]     w_occ_next;
  logic [ADDRESS_WIDTH-1:0] w_head_addr;

  // Handshake decode: a full queue still accepts a push when the head leaves.
  always_comb begin
    w_head_valid = (r_occupancy != '0);
    w_pop        = bus.pop && w_head_valid;
    w_req        = bus.in_op_ready_s && (bus.in_opcode != c_op_nop);
    w_push       = w_req && ((r_occupancy != c_full) || w_pop);
    w_occ_next   = r_occupancy;
    if (w_push && !w_pop) begin
      w_occ_next = r_occupancy + OCC_WIDTH'(1);
    end else if (w_pop && !w_push) begin
      w_occ_next = r_occupancy - OCC_WIDTH'(1);
    end
  end

  // Pointers and occupancy; full/empty come from occupancy only.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rd_ptr    <= '0;
      r_wr_ptr    <= '0;
      r_occupancy <= '0;
    end else begin
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_WIDTH'(1);
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_WIDTH'(1);
      r_occupancy <= w_occ_next;
    end
  end

  // Per-entry valid flag and saturating age; a fresh write wins over the pop
  // of the same slot when the queue is full.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_valid <= '0;
      for (int i = 0; i < DEPTH; i++) r_life[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_push && (r_wr_ptr == PTR_WIDTH'(i))) begin
          r_valid[i] <= 1'b1;
          r_life[i]  <= '0;
        end else begin
          if (w_pop && (r_rd_ptr == PTR_WIDTH'(i))) r_valid[i] <= 1'b0;
          if (r_valid[i] && (r_life[i] != c_life_sat)) r_life[i] <= r_life[i] + 7'd1;
        end
      end
    end
  end

  // Request payload storage; contents are only observed behind the valid flags.
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_opcode[r_wr_ptr]      <= bus.in_opcode;
      r_address[r_wr_ptr]     <= bus.in_address;
      r_clock_count[r_wr_ptr] <= bus.in_clock_count;
    end
  end

  // Head presentation: NOP and zeros whenever the queue is empty.
  always_comb begin
    w_head_addr         = r_address[r_rd_ptr];
    bus.queue_full      = (r_occupancy == c_full);
    bus.occupancy       = r_occupancy;
    bus.out_valid       = w_head_valid;
    bus.out_opcode      = c_op_nop;
    bus.out_address     = '0;
    bus.out_clock_count = '0;
    bus.out_bank_group  = '0;
    bus.out_bank        = '0;
    bus.out_column      = '0;
    bus.out_row         = '0;
    bus.out_life        = '0;
    bus.out_expired     = 1'b0;
    if (w_head_valid) begin
      bus.out_opcode      = r_opcode[r_rd_ptr];
      bus.out_address     = w_head_addr;
      bus.out_clock_count = r_clock_count[r_rd_ptr];
      bus.out_bank_group  = w_head_addr[BG_OFFSET +: 2];
      bus.out_bank        = w_head_addr[BANK_OFFSET +: 2];
      bus.out_column      = w_head_addr[COLUMN_OFFSET +: 8];
      bus.out_row         = w_head_addr[ROW_OFFSET +: 10];
      bus.out_life        = r_life[r_rd_ptr];
      bus.out_expired     = (r_life[r_rd_ptr] >= c_max_life);
    end
  end

`ifdef QUEUE_STATS_EN
  logic [OCC_WIDTH-1:0] r_peak;
  logic [15:0]          r_reject;

  // High-water mark and saturating count of refused real requests.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_peak   <= '0;
      r_reject <= '0;
    end else begin
      if (w_occ_next > r_peak) r_peak <= w_occ_next;
      if (w_req && !w_push && (r_reject != 16'hFFFF)) r_reject <= r_reject + 16'd1;
    end
  end

  assign bus.peak_occupancy = r_peak;
  assign bus.reject_count   = r_reject;
`endif
endmodule
`default_nettype wire

// File: tb/tb_mem_request_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_request_queue
// Purpose  : Randomised self-checking bench for mem_request_queue with a
//            queue-based reference model and literal spot checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_request_queue;
  localparam int DEPTH = 16;
  localparam int AW    = 32;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  mem_request_queue_if #(.DEPTH(DEPTH), .ADDRESS_WIDTH(AW)) bus ();

  mem_request_queue #(
    .DEPTH(DEPTH), .ADDRESS_WIDTH(AW), .BG_OFFSET(6), .BANK_OFFSET(8),
    .COLUMN_OFFSET(10), .ROW_OFFSET(18), .MAX_LIFE(100)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus.slave)
  );

  typedef struct {
    logic [1:0]  op;
    logic [31:0] addr;
    logic [31:0] cc;
    int          born;
  } ent_t;

  ent_t mq[$];
  int   edge_cnt = 0;
  int   checks   = 0;
  int   failures = 0;
  bit   chk_en   = 1'b0;
`ifdef QUEUE_STATS_EN
  int   m_peak   = 0;
  int   m_reject = 0;
`endif

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Expected head view derived from the model queue and elapsed edges.
  task automatic compare_outputs();
    logic [31:0] a;
    logic [31:0] cc;
    logic [1:0]  op;
    int          life;
    bit          v;
    a = '0; cc = '0; op = 2'd3; life = 0;
    v = (mq.size() > 0);
    if (v) begin
      a    = mq[0].addr;
      cc   = mq[0].cc;
      op   = mq[0].op;
      life = edge_cnt - mq[0].born;
      if (life > 127) life = 127;
    end
    check("out_valid",       64'(bus.out_valid),       64'(v));
    check("out_opcode",      64'(bus.out_opcode),      64'(op));
    check("out_address",     64'(bus.out_address),     64'(a));
    check("out_clock_count", 64'(bus.out_clock_count), 64'(cc));
    check("out_bank_group",  64'(bus.out_bank_group),  64'(a[7:6]));
    check("out_bank",        64'(bus.out_bank),        64'(a[9:8]));
    check("out_column",      64'(bus.out_column),      64'(a[17:10]));
    check("out_row",         64'(bus.out_row),         64'(a[27:18]));
    check("out_life",        64'(bus.out_life),        64'(life));
    check("out_expired",     64'(bus.out_expired),     64'(v && (life >= 100)));
    check("occupancy",       64'(bus.occupancy),       64'(mq.size()));
    check("queue_full",      64'(bus.queue_full),      64'(mq.size() == DEPTH));
`ifdef QUEUE_STATS_EN
    check("peak_occupancy",  64'(bus.peak_occupancy),  64'(m_peak));
    check("reject_count",    64'(bus.reject_count),    64'(m_reject));
`endif
  endtask

  // Single compare process, away from the active edge.
  always @(negedge clock) begin
    if (chk_en) compare_outputs();
  end

  // One clock cycle of stimulus; the model advances with the DUT edge.
  task automatic drive(input bit strobe, input logic [1:0] op, input logic [31:0] addr,
                       input logic [31:0] cc, input bit p);
    bit pop_ok;
    bit push_ok;
    bus.in_op_ready_s  = strobe;
    bus.in_opcode      = op;
    bus.in_address     = addr;
    bus.in_clock_count = cc;
    bus.pop            = p;
    pop_ok  = p && (mq.size() > 0);
    push_ok = strobe && (op != 2'd3) && ((mq.size() < DEPTH) || pop_ok);
    @(posedge clock);
    edge_cnt++;
    if (pop_ok) void'(mq.pop_front());
    if (push_ok) mq.push_back('{op: op, addr: addr, cc: cc, born: edge_cnt});
`ifdef QUEUE_STATS_EN
    if (strobe && (op != 2'd3) && !push_ok && (m_reject < 65535)) m_reject++;
    if (mq.size() > m_peak) m_peak = mq.size();
`endif
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 2'd0, 32'd0, 32'd0, 1'b0);
  endtask

  task automatic rand_cycle(input int strobe_pct, input int pop_pct);
    drive($urandom_range(0, 99) < strobe_pct, 2'($urandom_range(0, 3)),
          $urandom, $urandom, $urandom_range(0, 99) < pop_pct);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_op_ready_s  = 1'b0;
    bus.in_opcode      = 2'd0;
    bus.in_address     = '0;
    bus.in_clock_count = '0;
    bus.pop            = 1'b0;

    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    #1;
    check("rst_out_valid",  64'(bus.out_valid),  64'd0);
    check("rst_out_opcode", 64'(bus.out_opcode), 64'd3);
    check("rst_queue_full", 64'(bus.queue_full), 64'd0);
    check("rst_occupancy",  64'(bus.occupancy),  64'd0);
    chk_en = 1'b1;

    // Address split of a known request.
    drive(1'b1, 2'd1, 32'h0ABC_D5C0, 32'd1234, 1'b0);
    check("lit_valid",  64'(bus.out_valid),      64'd1);
    check("lit_bg",     64'(bus.out_bank_group), 64'd3);
    check("lit_bank",   64'(bus.out_bank),       64'd1);
    check("lit_column", 64'(bus.out_column),     64'h35);
    check("lit_row",    64'(bus.out_row),        64'h2AF);
    check("lit_life0",  64'(bus.out_life),       64'd0);
    idle();
    check("lit_life1",  64'(bus.out_life),       64'd1);
    idle();
    check("lit_life2",  64'(bus.out_life),       64'd2);

    // Expiry threshold and saturation.
    repeat (97) idle();
    check("lit_life99",    64'(bus.out_life),    64'd99);
    check("lit_expired99", 64'(bus.out_expired), 64'd0);
    idle();
    check("lit_life100",    64'(bus.out_life),    64'd100);
    check("lit_expired100", 64'(bus.out_expired), 64'd1);
    repeat (100) idle();
    check("lit_life_sat", 64'(bus.out_life), 64'd127);
    drive(1'b0, 2'd0, 32'd0, 32'd0, 1'b1);
    check("lit_pop_empty", 64'(bus.occupancy), 64'd0);

    // Fill, overflow attempt, pop+push while full, then drain.
    for (int i = 0; i < DEPTH; i++) drive(1'b1, 2'($urandom_range(0, 2)), $urandom, i, 1'b0);
    check("lit_full_occ", 64'(bus.occupancy),  64'd16);
    check("lit_full",     64'(bus.queue_full), 64'd1);
    drive(1'b1, 2'd2, 32'hDEAD_BEEF, 32'd99, 1'b0);
    check("lit_overflow_occ", 64'(bus.occupancy), 64'd16);
    drive(1'b1, 2'd0, 32'hCAFE_F00D, 32'd77, 1'b1);
    check("lit_swap_occ",  64'(bus.occupancy),  64'd16);
    check("lit_swap_full", 64'(bus.queue_full), 64'd1);
    for (int i = 0; i < DEPTH; i++) drive(1'b0, 2'd0, 32'd0, 32'd0, 1'b1);
    check("lit_drained", 64'(bus.occupancy), 64'd0);

    // NOP strobe is dropped.
    drive(1'b1, 2'd1, 32'h1234_5678, 32'd7, 1'b0);
    drive(1'b1, 2'd3, 32'hFFFF_FFFF, 32'd9, 1'b0);
    check("lit_nop_occ",  64'(bus.occupancy),   64'd1);
    check("lit_nop_head", 64'(bus.out_address), 64'h1234_5678);
    drive(1'b0, 2'd0, 32'd0, 32'd0, 1'b1);

    // Pop on empty, then a wrapping push/pop run.
    repeat (3) drive(1'b0, 2'd0, 32'd0, 32'd0, 1'b1);
    check("lit_underflow", 64'(bus.occupancy), 64'd0);
    drive(1'b1, 2'd2, $urandom, 32'd100, 1'b0);
    for (int i = 1; i < 20; i++) drive(1'b1, 2'($urandom_range(0, 2)), $urandom, 100 + i, 1'b1);
    drive(1'b0, 2'd0, 32'd0, 32'd0, 1'b1);
    check("lit_wrap_empty", 64'(bus.occupancy), 64'd0);

    // Random traffic, fill-biased then drain-biased.
    repeat (1000) rand_cycle(80, 30);
    repeat (1000) rand_cycle(30, 70);

    // Asynchronous reset with five entries held.
    for (int i = 0; i < 40 && mq.size() > 0; i++) drive(1'b0, 2'd0, 32'd0, 32'd0, 1'b1);
    for (int i = 0; i < 5; i++) drive(1'b1, 2'd1, $urandom, i, 1'b0);
    check("lit_pre_reset_occ", 64'(bus.occupancy), 64'd5);
    reset = 1'b1;
    #1;
    check("mid_rst_out_valid",  64'(bus.out_valid),  64'd0);
    check("mid_rst_out_opcode", 64'(bus.out_opcode), 64'd3);
    check("mid_rst_queue_full", 64'(bus.queue_full), 64'd0);
    check("mid_rst_occupancy",  64'(bus.occupancy),  64'd0);
`ifdef QUEUE_STATS_EN
    check("mid_rst_peak",   64'(bus.peak_occupancy), 64'd0);
    check("mid_rst_reject", 64'(bus.reject_count),   64'd0);
    m_peak   = 0;
    m_reject = 0;
`endif
    mq.delete();
    #2 reset = 1'b0;
    #1;
    repeat (200) rand_cycle(60, 50);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
